result_mem_writer: RTL and testbench
====================================

Name: result_mem_writer

Overview:
- Write-side counterpart of the result-memory VGA reader.
- Accepts the processed 8-bit grayscale pixel stream from the image-processing core over a valid/ready handshake.
- Writes each pixel in raster order into the dual-port result memory at a row-strided address.
- Raises a done level once the full frame is committed, so the display side can start reading.

Parameters:
- WIDTH, 320, pixels per row written.
- HEIGHT, 320, rows per frame.
- STRIDE, 320, address increment between row starts; must be >= WIDTH.
- BASE, 0, address of pixel (0,0).
- ADDR_W, 18, memory address width; BASE+(HEIGHT-1)*STRIDE+WIDTH-1 must fit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a new frame.
- in_valid  in  1  producer has a pixel on in_data.
- in_data  in  8  grayscale pixel value.
- in_eof  in  1  producer marks the last pixel of its frame; qualified by in_valid.
- in_ready  out  1  writer accepts a beat this cycle.
- mem_wren  out  1  write strobe to result memory port A.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  8  write data.
- busy  out  1  frame in progress (WRITE or FLUSH).
- done  out  1  level: frame fully committed.
- err  out  1  level: in_eof position mismatched the frame size; cleared by start.

Behaviour:
- Reset: state IDLE. in_ready, mem_wren, busy, done and err all 0. mem_addr = 0, mem_data = 0, x = 0, y = 0, row_base = BASE.
- Beat accepted when in_valid && in_ready. in_ready = 1 only in state WRITE (combinational from state).
- States and transitions:
  - IDLE: start -> WRITE; clear x, y, err; row_base = BASE.
  - WRITE: in_ready = 1, busy = 1. start is ignored.
  - FLUSH: exactly one cycle, busy = 1, then -> DONE.
  - DONE: done = 1, in_ready = 0. start -> WRITE; clear done, err, x, y and row_base in the same edge.
- Write latency is one cycle. A beat accepted at edge t gives mem_wren = 1 during cycle t+1, with mem_addr = row_base + x and mem_data = in_data sampled at t. Otherwise mem_wren = 0; mem_addr and mem_data hold their last values.
- Counters update only on accepted beats:
  - x increments.
  - When x = WIDTH-1: x wraps to 0, y increments, row_base += STRIDE.
  - Address arithmetic is ADDR_W bits, incremental only (no multiplier).
- Frame end is the accepted beat at x = WIDTH-1, y = HEIGHT-1, or any accepted beat with in_eof = 1, whichever comes first. On frame end -> FLUSH, so the final write occurs in FLUSH and done rises the following cycle (2 cycles after the last accept).
- err = 1 when:
  - in_eof = 1 on a beat that is not the final position (short frame), or
  - the final-position beat has in_eof = 0 (long frame; the producer's remaining pixels see in_ready = 0 and are never written).
- Backpressure: in_valid low in WRITE simply stalls; counters hold, no write.
- Start pulse in the same cycle as rst: reset wins.
- Reset mid-frame: return to IDLE next edge; any pending mem_wren is cancelled (mem_wren = 0 after reset). Partial memory contents are left as-is.
- in_data and in_eof are don't-care when in_valid = 0.

Test Plan:
(All with WIDTH=4, HEIGHT=3, STRIDE=8, BASE=16, ADDR_W=8 unless noted.)
1. start, then 12 back-to-back beats with data 0..11, in_eof on the 12th -> 12 writes to addresses 16,17,18,19,24..27,32..35 carrying data 0..11; done=1 two cycles after the 12th accept; err=0; busy=0 in DONE.
2. Same frame with in_valid toggling 1/0 each cycle -> identical address/data sequence; no mem_wren in cycles following a non-accept; done after the last beat.
3. in_eof on beat 6 (data 5) -> writes only to 16..19,24,25; err=1; done=1; in_ready=0 afterwards.
4. 12 beats with no in_eof -> 12 writes, err=1; a 13th in_valid is held with in_ready=0 and never written.
5. rst asserted during the cycle after the 5th accept -> mem_wren=0 next cycle; state IDLE; done=0; new start writes data 0 to address 16 again.
6. start pulsed mid-frame (ignored), then start in DONE -> done and err clear on the same edge; second frame rewrites from address 16.

Source files
------------

// File: rtl/result_mem_writer.sv
// result_mem_writer
//   Write side of the result frame buffer. It takes the processed 8-bit
//   grayscale stream from the image-processing core over valid/ready and
//   writes each pixel in raster order into port A of the dual-port result
//   memory. Each row starts STRIDE words after the previous one. When the
//   whole frame has been committed, the done level rises so the VGA reader
//   can start scanning.
//
// Ports
//   clk, rst   system clock, synchronous active-high reset
//   start      one-cycle pulse; arms a new frame from IDLE or DONE
//   in_valid   producer has a beat on in_data / in_eof
//   in_data    8-bit pixel
//   in_eof     producer's last pixel of the frame (qualified by in_valid)
//   in_ready   writer accepts a beat this cycle (only while writing)
//   mem_wren   write strobe, one cycle after the accepted beat
//   mem_addr   write address, BASE + y*STRIDE + x
//   mem_data   write data
//   busy       frame in progress (WRITE or FLUSH)
//   done       level: frame fully committed
//   err        level: in_eof did not line up with the frame size
//
// Parameters
//   WIDTH/HEIGHT  frame size in pixels
//   STRIDE        address distance between row starts (>= WIDTH)
//   BASE          address of pixel (0,0)
//   ADDR_W        address width; the last pixel address must fit
module result_mem_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 320,
  parameter int STRIDE = 320,
  parameter int BASE   = 0,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_eof,
  output logic              in_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [XW-1:0]     X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FLUSH,
    DONE
  } state_t;

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] row_base;   // address of (0,y), stepped by STRIDE

  logic accept;
  logic x_last;
  logic last_pos;

  assign in_ready = (state == WRITE);
  assign accept   = in_valid && in_ready;
  assign x_last   = (x == X_LAST);
  assign last_pos = x_last && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_wren <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= BASE_A;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // One-stage write pipe: the address is formed from the counters as
      // they stood when the beat was taken, so no multiply is ever needed.
      // Address/data hold between writes.
      mem_wren <= accept;
      if (accept) begin
        mem_addr <= row_base + ADDR_W'(x);
        mem_data <= in_data;
        if (x_last) begin
          x        <= '0;
          y        <= y + 1'b1;
          row_base <= row_base + STRIDE_A;
        end else begin
          x <= x + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= WRITE;
            busy     <= 1'b1;
            err      <= 1'b0;
            x        <= '0;
            y        <= '0;
            row_base <= BASE_A;
          end
        end

        WRITE: begin
          // Frame ends on the last raster position or an early eof. The two
          // agreeing is the only clean case; either one alone flags err.
          // Beats offered after a long frame see in_ready low and are lost.
          if (accept && (last_pos || in_eof)) begin
            state <= FLUSH;
            err   <= last_pos ^ in_eof;
          end
        end

        FLUSH: begin
          // The final memory write is on the bus this cycle; done only
          // rises once it has been committed.
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        DONE: begin
          if (start) begin
            state    <= WRITE;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            x        <= '0;
            y        <= '0;
            row_base <= BASE_A;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_mem_writer.sv
module tb_result_mem_writer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int S  = 8;
  localparam int B  = 16;
  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_eof;
  logic          in_ready;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          busy;
  logic          done;
  logic          err;

  result_mem_writer #(
    .WIDTH(W), .HEIGHT(H), .STRIDE(S), .BASE(B), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_eof(in_eof),
    .in_ready(in_ready),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a count of accepted pixels; pixel k lands at
  // B + (k/W)*S + k%W. Accepting stops at W*H pixels or on eof, one flush
  // cycle follows, then done.
  bit        m_act, m_fl, m_done, m_err, m_wren;
  bit        was_act, was_fl;
  int        m_cnt;
  logic [7:0] m_addr, m_data;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_fl = 0; m_done = 0; m_err = 0; m_wren = 0;
      m_cnt = 0; m_addr = '0; m_data = '0;
    end else begin
      was_act = m_act;
      was_fl  = m_fl;
      m_wren  = was_act && in_valid;
      if (m_wren) begin
        m_addr = 8'(B + (m_cnt / W) * S + (m_cnt % W));
        m_data = in_data;
        m_cnt++;
        if (m_cnt == W * H || in_eof) begin
          m_act = 0;
          m_fl  = 1;
          m_err = ((m_cnt == W * H) != in_eof);
        end
      end
      if (was_fl) begin
        m_fl   = 0;
        m_done = 1;
      end
      if (start && !was_act && !was_fl) begin
        m_act = 1; m_done = 0; m_err = 0; m_cnt = 0;
      end
    end
  end

  // Write log seen on the memory port, for the literal checks.
  int wa[$];
  int wd[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_act));
      chk("busy",     32'(busy),     32'(m_act || m_fl));
      chk("done",     32'(done),     32'(m_done));
      chk("err",      32'(err),      32'(m_err));
      chk("mem_wren", 32'(mem_wren), 32'(m_wren));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_data", 32'(mem_data), 32'(m_data));
      if (mem_wren) begin
        wa.push_back(int'(mem_addr));
        wd.push_back(int'(mem_data));
      end
    end
  end

  // Drives one frame: start pulse, then beats until done (or a reset after
  // rst_after accepts). vmode 0 = always valid, 1 = toggling, 2 = random.
  task automatic run_frame(input int eof_at, input int vmode, input bit seq_data,
                           input int mid_start_at, input int rst_after);
    int beat;
    int cyc;
    bit rdy;
    bit did_rst;
    beat = 0; cyc = 0; did_rst = 0;
    wa.delete(); wd.delete();
    start = 1'b1; in_valid = 1'b0; in_eof = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 200) begin
      in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? cyc[0] : ($urandom_range(0, 99) < 60);
      in_data  = seq_data ? beat[7:0] : 8'($urandom);
      in_eof   = (beat == eof_at);
      start    = (cyc == mid_start_at);
      rst      = (rst_after >= 0 && beat == rst_after);
      rdy      = in_ready;
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
        did_rst = 1;
        break;
      end
      if (in_valid && rdy) beat++;
      cyc++;
    end
    in_valid = 1'b0; in_eof = 1'b0; start = 1'b0;
    if (!did_rst) chk("frame_done", 32'(done), 32'd1);
  endtask

  int exp_addr [12] = '{16, 17, 18, 19, 24, 25, 26, 27, 32, 33, 34, 35};

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_eof = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    start = 1'b1;                      // start together with reset: reset wins
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_wren",  32'(mem_wren), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // 1: back-to-back clean frame
    run_frame(11, 0, 1, -1, -1);
    chk("t1_count", wa.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk("t1_addr", wa[k], exp_addr[k]);
      chk("t1_data", wd[k], k);
    end
    chk("t1_err", 32'(err), 0);
    chk("t1_busy", 32'(busy), 0);

    // 2: toggling valid
    run_frame(11, 1, 1, -1, -1);
    chk("t2_count", wa.size(), 12);
    for (int k = 0; k < 12; k++) chk("t2_addr", wa[k], exp_addr[k]);

    // 3: short frame, eof on data 5
    run_frame(5, 0, 1, -1, -1);
    chk("t3_count", wa.size(), 6);
    chk("t3_last_addr", wa[5], 25);
    chk("t3_err", 32'(err), 1);
    chk("t3_ready", 32'(in_ready), 0);

    // 4: long frame, no eof; a 13th beat is offered but never written
    run_frame(-1, 0, 1, -1, -1);
    chk("t4_count", wa.size(), 12);
    chk("t4_err", 32'(err), 1);

    // 5: reset in the cycle after the 5th accept, then a fresh frame
    run_frame(11, 0, 1, -1, 5);
    chk("t5_count", wa.size(), 5);
    chk("t5_done", 32'(done), 0);
    run_frame(11, 0, 1, -1, -1);
    chk("t5_first_addr", wa[0], 16);
    chk("t5_first_data", wd[0], 0);

    // 6: ignored mid-frame start, then restart from DONE with err set
    run_frame(5, 0, 1, 3, -1);
    chk("t6_err", 32'(err), 1);
    run_frame(11, 0, 1, -1, -1);
    chk("t6_count", wa.size(), 12);
    chk("t6_first_addr", wa[0], 16);
    chk("t6_err2", 32'(err), 0);

    // random frames: random valid density, data, eof placement, resets
    for (int f = 0; f < 12; f++) begin
      int r;
      int eof_at;
      int ra;
      r = int'($urandom_range(0, 3));
      eof_at = (r == 0) ? int'($urandom_range(0, 11)) : (r == 1) ? -1 : 11;
      ra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : -1;
      run_frame(eof_at, 2, 0, int'($urandom_range(0, 15)), ra);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
